// File: rtl/vrshft_engine_if.sv
// Handshake and data bundle for vrshft_engine: request/operand side plus result/status side.
interface vrshft_engine_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SHAMT_WIDTH = 5
);
  logic                   START;
  logic [2:0]             MODE;
  logic [SHAMT_WIDTH-1:0] SHAMT;
  logic [DATA_WIDTH-1:0]  D;
  logic                   RIN;
  logic                   LIN;
  logic [DATA_WIDTH-1:0]  Q;
  logic                   BUSY;
  logic                   DONE;
  logic                   OVF;

  modport master (
    output START, MODE, SHAMT, D, RIN, LIN,
    input  Q, BUSY, DONE, OVF
  );

  modport slave (
    input  START, MODE, SHAMT, D, RIN, LIN,
    output Q, BUSY, DONE, OVF
  );
endinterface

// File: rtl/vrshft_engine.sv
// Multi-cycle shift engine: shifts the latched operand by up to STEP bits per clock,
// with logical, rotate, arithmetic (overflow-tracking) and rounded arithmetic-right modes.
module vrshft_engine #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SHAMT_WIDTH = 5,
  parameter int unsigned STEP        = 1
) (
  input logic            CLK,
  input logic            RSTN,
  vrshft_engine_if.slave bus
);
  localparam int unsigned SW = $clog2(DATA_WIDTH);
  localparam int unsigned AW = SW + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND} state_e;
  typedef enum logic [2:0] {
    M_LSR  = 3'd0,
    M_LSL  = 3'd1,
    M_ROR  = 3'd2,
    M_ROL  = 3'd3,
    M_ASR  = 3'd4,
    M_ASL  = 3'd5,
    M_ASRR = 3'd6,
    M_NOP  = 3'd7
  } mode_e;

  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0]  q_q, q_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   rin_q, rin_d;
  logic                   lin_q, lin_d;
  logic                   ovf_q, ovf_d;
  logic                   g_q, g_d;
  logic                   done_q, done_d;

  logic [SW-1:0]          step_amt;
  logic [SW-1:0]          top_sh;
  logic [SW-1:0]          g_idx;
  logic [AW-1:0]          rot_amt;
  logic [DATA_WIDTH-1:0]  ones;
  logic [DATA_WIDTH-1:0]  shifted;
  logic [DATA_WIDTH-1:0]  top_bits;
  logic                   ovf_step;
  logic                   guard;

  // Per-step amount: the remaining count, capped at STEP.
  always_comb begin
    if (32'(cnt_q) > STEP) step_amt = SW'(STEP);
    else                   step_amt = SW'(cnt_q);
  end

  always_comb begin
    ones    = '1;
    rot_amt = AW'(DATA_WIDTH) - {1'b0, step_amt};
    top_sh  = SW'(DATA_WIDTH - 1) - step_amt;
    g_idx   = step_amt - SW'(1);
    // Sign-extending the top step_amt+1 bits down to bit 0 yields all-0 or all-1
    // exactly when those bits agree, i.e. when no significant bit leaves.
    top_bits = $unsigned($signed(q_q) >>> top_sh);
    ovf_step = (top_bits != '0) && (top_bits != '1);
    guard    = q_q[g_idx];
    case (mode_q)
      M_LSR:         shifted = (q_q >> step_amt) | (rin_q ? ~(ones >> step_amt) : '0);
      M_LSL:         shifted = (q_q << step_amt) | (lin_q ? ~(ones << step_amt) : '0);
      M_ROR:         shifted = (q_q >> step_amt) | (q_q << rot_amt);
      M_ROL:         shifted = (q_q << step_amt) | (q_q >> rot_amt);
      M_ASR, M_ASRR: shifted = $unsigned($signed(q_q) >>> step_amt);
      M_ASL:         shifted = q_q << step_amt;
      default:       shifted = q_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    rin_d   = rin_q;
    lin_d   = lin_q;
    ovf_d   = ovf_q;
    g_d     = g_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          q_d   = bus.D;
          mode_d = mode_e'(bus.MODE);
          cnt_d = bus.SHAMT;
          rin_d = bus.RIN;
          lin_d = bus.LIN;
          ovf_d = 1'b0;
          if (bus.SHAMT != '0 && mode_e'(bus.MODE) != M_NOP) state_d = SHIFT;
          else                                                done_d  = 1'b1;
        end
      end
      SHIFT: begin
        q_d   = shifted;
        cnt_d = cnt_q - SHAMT_WIDTH'(step_amt);
        g_d   = guard;
        if (mode_q == M_ASL && ovf_step) ovf_d = 1'b1;
        if (cnt_d == '0) begin
          if (mode_q == M_ASRR) begin
            state_d = ROUND;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ROUND: begin
        q_d     = q_q + DATA_WIDTH'(g_q);
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      mode_q  <= M_LSR;
      q_q     <= '0;
      cnt_q   <= '0;
      rin_q   <= 1'b0;
      lin_q   <= 1'b0;
      ovf_q   <= 1'b0;
      g_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      rin_q   <= rin_d;
      lin_q   <= lin_d;
      ovf_q   <= ovf_d;
      g_q     <= g_d;
      done_q  <= done_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.BUSY = (state_q != IDLE);
  assign bus.DONE = done_q;
  assign bus.OVF  = ovf_q;
endmodule
